pipelined_adder: RTL and testbench

- Parametrised N-bit adder/subtractor built as a carry-chain split into STAGES equal segments, one register stage per segment.
- Successor to the single-bit full adders. Adds width generalisation, a subtract mode, signed-overflow detection and a valid/ready handshake with backpressure.
- Used as the standard arithmetic datapath primitive in the adders library.

---
 rtl/adders_pkg.sv | 20 ++
 rtl/adder_segment.sv | 34 +++
 rtl/full_adder.sv | 15 +
 rtl/pipelined_adder.sv | 113 +++++++++++
 tb/tb_pipelined_adder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/adders_pkg.sv
// Shared definitions for the adders library.
// Holds default widths, the segment-width helper and the add/sub mode encoding.
package adders_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Bits handled by one pipeline segment. A zero stage count is reported by
  // the elaboration check in the top, so just avoid dividing by zero here.
  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational SEG-bit ripple-carry segment built from full_adder cells.
// Ports: a_i, b_i  SEG-bit operands (already inverted for subtract)
//        cin_i     carry into bit 0
//        s_o       SEG-bit sum
//        cout_o    carry out of the MSB
//        cmsb_o    carry into the MSB (used for signed overflow)
module adder_segment #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] s_o,
  output logic           cout_o,
  output logic           cmsb_o
);

  logic [SEG:0] c;
  assign c[0] = cin_i;

  for (genvar i = 0; i < SEG; i++) begin : g_fa
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (s_o[i]),
      .c_o (c[i+1])
    );
  end

  assign cout_o = c[SEG];
  assign cmsb_o = c[SEG-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
// Ports: a_i, b_i, c_i  operand bits and carry-in
//        s_o, c_o       sum bit and carry-out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// segments with one register stage per segment and a valid/ready handshake.
// Ports: clk, rst            clock, synchronous active-high reset
//        in_valid/in_ready   operand handshake (in_ready = advance enable)
//        a, b, cin, sub      operands, carry/borrow-in, 0=add 1=subtract
//        out_valid/out_ready result handshake
//        sum, cout, ovf      result, carry-out (sub: 1 = no borrow), signed ovf
module pipelined_adder
  import adders_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  mode_e              mode;
  logic               en;
  logic [WIDTH-1:0]   b_eff;
  logic               cin_eff;
  logic [STAGES-1:0]  vld_q;
  logic [STAGES-1:0]  c_q;   // carry out of each segment, registered
  logic [STAGES-1:0]  co_w;
  logic [STAGES-1:0]  cm_w;
  logic               ovf_q;

  // Subtract is a + ~b + ~cin, so borrow-in flips with the operand.
  assign mode    = mode_e'(sub);
  assign b_eff   = (mode == SUB) ? ~b : b;
  assign cin_eff = (mode == SUB) ? ~cin : cin;

  // Whole pipeline advances in lockstep; bubbles are never collapsed.
  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= (vld_q << 1) | STAGES'(in_valid);
      c_q   <= co_w;
      ovf_q <= co_w[STAGES-1] ^ cm_w[STAGES-1];
    end
  end

  for (genvar j = 0; j < STAGES; j++) begin : g_seg
    logic [SEG-1:0] opa, opb, s_w;
    logic           ci;

    if (j == 0) begin : g_head
      assign opa = a[SEG-1:0];
      assign opb = b_eff[SEG-1:0];
      assign ci  = cin_eff;
    end else begin : g_skew
      // Operand bits for segment j wait j cycles to meet their carry.
      // Not reset: a stale value can only sit under a cleared valid bit.
      logic [2*SEG-1:0] sk_q [j];
      always_ff @(posedge clk) begin
        if (en) begin
          sk_q[0] <= {b_eff[j*SEG +: SEG], a[j*SEG +: SEG]};
          for (int i = 1; i < j; i++) sk_q[i] <= sk_q[i-1];
        end
      end
      assign {opb, opa} = sk_q[j-1];
      assign ci         = c_q[j-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a_i    (opa),
      .b_i    (opb),
      .cin_i  (ci),
      .s_o    (s_w),
      .cout_o (co_w[j]),
      .cmsb_o (cm_w[j])
    );

    // Deskew: lower segments finish early and are held until the top one lands.
    logic [SEG-1:0] dsk_q [STAGES-j];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < STAGES - j; i++) dsk_q[i] <= '0;
      end else if (en) begin
        dsk_q[0] <= s_w;
        for (int i = 1; i < STAGES - j; i++) dsk_q[i] <= dsk_q[i-1];
      end
    end
    assign sum[j*SEG +: SEG] = dsk_q[STAGES-1-j];
  end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk, rst;
  logic        in_valid, cin, sub;
  logic [15:0] a, b;
  logic [2:0]  irdy, ovld, ordy, cw, ov;
  logic [15:0] sm [3];

  int n_tests = 0;
  int n_fail  = 0;
  res_t q [3][$];
  string nm [3] = '{"S4", "S1", "S16"};

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(sm[0]),
    .cout(cw[0]), .ovf(ov[0]));
  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(sm[1]),
    .cout(cw[1]), .ovf(ov[1]));
  pipelined_adder #(.WIDTH(16), .STAGES(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(sm[2]),
    .cout(cw[2]), .ovf(ov[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: plain integer add/subtract and signed range test.
  function automatic res_t model(input logic [15:0] va, input logic [15:0] vb,
                                 input logic vc, input logic vs);
    res_t r;
    int full, sr;
    if (!vs) begin
      full   = int'(va) + int'(vb) + int'(vc);
      r.cout = full > 65535;
      sr     = int'(signed'(va)) + int'(signed'(vb)) + int'(vc);
    end else begin
      full   = int'(va) - int'(vb) - int'(vc);
      r.cout = full >= 0;
      sr     = int'(signed'(va)) - int'(signed'(vb)) - int'(vc);
    end
    r.sum = full[15:0];
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  function automatic logic [15:0] pick16();
    logic [15:0] corner [4] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    if ($urandom_range(3) == 0) return corner[$urandom_range(3)];
    return 16'($urandom);
  endfunction

  // Scoreboard: every result must match the oldest accepted operation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ovld[d]) begin
        chk($sformatf("%s result pending", nm[d]), 32'(q[d].size() != 0), 32'd1);
        if (q[d].size() != 0) begin
          chk($sformatf("%s result", nm[d]), {14'd0, sm[d], cw[d], ov[d]}, {14'd0, q[d][0]});
          if (ordy[d] && !rst) void'(q[d].pop_front());
        end
      end
      if (in_valid && irdy[d] && !rst) q[d].push_back(model(a, b, cin, sub));
      if (rst) q[d].delete();
    end
  end

  task automatic run_vec(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic vs,
                         input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, " S1 latency"}, 32'(ovld[1]), 32'd1);
    lat = 1;
    while (!ovld[0] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " sum"}, 32'(sm[0]), 32'(es));
    chk({tag, " cout"}, 32'(cw[0]), 32'(ec));
    chk({tag, " ovf"}, 32'(ov[0]), 32'(eo));
    @(posedge clk); #1;
  endtask

  initial begin
    res_t exp_q [8];
    res_t first;
    int   n;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; ordy = 3'b111;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset out_valid", 32'(ovld[0]), 32'd0);
    chk("reset sum", 32'(sm[0]), 32'd0);
    chk("reset cout", 32'(cw[0]), 32'd0);
    chk("reset ovf", 32'(ov[0]), 32'd0);
    chk("reset in_ready", 32'(irdy[0]), 32'd1);

    run_vec("add carry chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_vec("add overflow",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_vec("sub borrow",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_vec("sub overflow",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_vec("add cin",         16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
    run_vec("sub borrow-in",   16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

    // Back-to-back: 8 accepted on consecutive edges, results on edges 4..11.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        a = pick16(); b = pick16(); cin = 1'($urandom); sub = 1'($urandom);
        exp_q[k] = model(a, b, cin, sub);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (k + 1 < 4) begin
        chk("b2b early valid", 32'(ovld[0]), 32'd0);
      end else begin
        chk($sformatf("b2b valid %0d", k - 3), 32'(ovld[0]), 32'd1);
        chk($sformatf("b2b data %0d", k - 3), {14'd0, sm[0], cw[0], ov[0]}, {14'd0, exp_q[k-3]});
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: fill, stall 3 cycles with junk offered, then drain.
    for (int k = 0; k < 4; k++) begin
      a = pick16(); b = pick16(); cin = 1'($urandom); sub = 1'($urandom);
      if (k == 0) first = model(a, b, cin, sub);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    chk("bp full valid", 32'(ovld[0]), 32'd1);
    ordy[0] = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
    #1 chk("bp in_ready", 32'(irdy[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp stall valid", 32'(ovld[0]), 32'd1);
      chk("bp stall data", {14'd0, sm[0], cw[0], ov[0]}, {14'd0, first});
      chk("bp stall in_ready", 32'(irdy[0]), 32'd0);
    end
    ordy[0] = 1'b1; in_valid = 1'b0;
    n = 0;
    while (q[0].size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp drained", q[0].size(), 0);

    // Reset with two operations in flight, plus operands during reset.
    for (int k = 0; k < 2; k++) begin
      a = pick16(); b = pick16(); cin = 1'($urandom); sub = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1; a = 16'($urandom); b = 16'($urandom);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst out_valid", 32'(ovld[0]), 32'd0);
    chk("rst in_ready", 32'(irdy[0]), 32'd1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      chk("rst S4 quiet", 32'(ovld[0]), 32'd0);
      chk("rst S16 quiet", 32'(ovld[2]), 32'd0);
    end

    // Random traffic with random backpressure on all three configurations.
    for (int k = 0; k < 400; k++) begin
      in_valid = ($urandom_range(3) != 0);
      a = pick16(); b = pick16(); cin = 1'($urandom); sub = 1'($urandom);
      for (int d = 0; d < 3; d++) ordy[d] = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; ordy = 3'b111;
    n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int d = 0; d < 3; d++) chk($sformatf("%s final drain", nm[d]), q[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
